// File: rtl/reg_dump_ctrl.sv
// Register-file dump engine: walks addresses 0..NUM_REGS-1, captures each word once,
// and streams header, data bytes (MSB first) and an XOR checksum over valid/ready.
module reg_dump_ctrl #(
    parameter int          NUM_REGS = 32,
    parameter int          ADDR_W   = 5,
    parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [2:0]        fsm_state
);

    // Handshake: a byte moves on a posedge where out_valid && out_ready; while
    // out_valid is high and out_ready low, out_data and rd_addr stay put, and
    // out_valid only falls after a transfer.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_LOAD = 3'd2,
        S_SEND = 3'd3,
        S_CSUM = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(NUM_REGS - 1);

    state_t          state;
    logic [ADDR_W:0] index;
    logic [ADDR_W:0] index_next;
    logic [31:0]     shift;
    logic [7:0]      checksum;
    logic [1:0]      byte_cnt;
    logic            xfer;

    // Index is one bit wider than the address so NUM_REGS=32 compares cleanly.
    assign index_next = index + 1'b1;
    assign xfer       = out_valid && out_ready;
    assign fsm_state  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rd_addr   <= '0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            checksum  <= 8'h00;
            index     <= '0;
            byte_cnt  <= 2'd0;
            shift     <= 32'h0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    rd_addr   <= '0;
                    if (start) begin
                        state     <= S_HDR;
                        checksum  <= 8'h00;
                        index     <= '0;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_data  <= HDR_BYTE;
                    end
                end
                S_HDR: begin
                    if (xfer) begin
                        state     <= S_LOAD;
                        out_valid <= 1'b0;
                        rd_addr   <= index[ADDR_W-1:0];
                    end
                end
                S_LOAD: begin
                    // The only cycle this register is sampled; later writes cannot leak in.
                    shift     <= rd_data;
                    out_data  <= rd_data[31:24];
                    byte_cnt  <= 2'd0;
                    out_valid <= 1'b1;
                    state     <= S_SEND;
                end
                S_SEND: begin
                    if (xfer) begin
                        checksum <= checksum ^ shift[31:24];
                        shift    <= {shift[23:0], 8'h00};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (index == LAST_IDX) begin
                                state    <= S_CSUM;
                                out_data <= checksum ^ shift[31:24];
                            end else begin
                                state     <= S_LOAD;
                                out_valid <= 1'b0;
                                index     <= index_next;
                                rd_addr   <= index_next[ADDR_W-1:0];
                            end
                        end else begin
                            out_data <= shift[23:16];
                        end
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        state     <= S_DONE;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    rd_addr  <= '0;
                    out_data <= 8'h00;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Directed bench for reg_dump_ctrl with a behavioural register file and a byte scoreboard.
module tb_reg_dump_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [2:0]  fsm_state;

    logic [31:0] regs [32];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];

    int checks;
    int errors;
    int cyc;
    int first_valid_cyc;
    int done_cyc;
    int done_cnt;

    reg_dump_ctrl #(.NUM_REGS(32), .ADDR_W(5), .HDR_BYTE(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .fsm_state (fsm_state)
    );

    assign rd_data = regs[rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Sample at the negedge, then advance one full cycle.
    task automatic tick();
        if (out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back(out_data);
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_capture();
        got_q.delete();
        first_valid_cyc = -1;
        done_cyc        = -1;
        done_cnt        = 0;
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        timed_out = (done_cnt == 0);
    endtask

    function automatic void build_expected();
        logic [7:0]  csum;
        logic [31:0] w;
        exp_q.delete();
        csum = 8'h00;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 32; i++) begin
            w = regs[i];
            for (int b = 3; b >= 0; b--) begin
                exp_q.push_back(w[8*b +: 8]);
                csum = csum ^ w[8*b +: 8];
            end
        end
        exp_q.push_back(csum);
    endfunction

    function automatic logic [7:0] get_byte(input int i);
        if (i < got_q.size()) return got_q[i];
        return 8'hxx;
    endfunction

    function automatic void load_pattern();
        for (int i = 0; i < 32; i++) begin
            regs[i] = {i[7:0], ~i[7:0], 8'h3C, i[7:0] ^ 8'h5A};
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || rd_addr !== 5'd0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: busy=%b out_valid=%b done=%b rd_addr=%0d, required 0 0 0 0",
                         k, busy, out_valid, done, rd_addr);
            end
        end
        rst = 1'b0;
        start = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || fsm_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_no_start: busy=%b out_valid=%b state=%0d, required 0 0 0",
                     busy, out_valid, fsm_state);
        end
    endtask

    task automatic test_full_dump();
        bit to;
        int start_cyc;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[12] = 32'hDEADBEEF;
        build_expected();
        clear_capture();
        out_ready = 1'b1;
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        wait_done(400, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL full_timeout: no done within budget, got %0d bytes", got_q.size());
        end
        checks++;
        if (got_q.size() != 130) begin
            errors++;
            $display("FAIL full_len: got %0d bytes, required 130", got_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (get_byte(i) !== exp_q[i]) begin
                errors++;
                $display("FAIL full_byte[%0d]: got %h, required %h", i, get_byte(i), exp_q[i]);
            end
        end
        checks++;
        if (get_byte(0) !== 8'hA5 || get_byte(49) !== 8'hDE || get_byte(50) !== 8'hAD ||
            get_byte(51) !== 8'hBE || get_byte(52) !== 8'hEF || get_byte(129) !== 8'h22) begin
            errors++;
            $display("FAIL full_spot: got %h %h %h %h %h %h, required a5 de ad be ef 22",
                     get_byte(0), get_byte(49), get_byte(50), get_byte(51), get_byte(52), get_byte(129));
        end
        checks++;
        if (first_valid_cyc - start_cyc != 1) begin
            errors++;
            $display("FAIL start_latency: got %0d cycles, required 1", first_valid_cyc - start_cyc);
        end
        checks++;
        if (done_cyc - first_valid_cyc != 162) begin
            errors++;
            $display("FAIL done_timing: got %0d cycles, required 162", done_cyc - first_valid_cyc);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || rd_addr !== 5'd0 || fsm_state !== 3'd0) begin
            errors++;
            $display("FAIL full_idle_after: busy=%b rd_addr=%0d state=%0d, required 0 0 0",
                     busy, rd_addr, fsm_state);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int stall_n;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[12] = 32'hDEADBEEF;
        build_expected();
        clear_capture();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        stall_n = 0;
        while (done_cnt == 0 && n < 400) begin
            if (got_q.size() == 50 && stall_n < 3) begin
                out_ready = 1'b0;
                checks++;
                if (out_data !== 8'hAD || rd_addr !== 5'd12 || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold[%0d]: data=%h rd_addr=%0d valid=%b, required ad 12 1",
                             stall_n, out_data, rd_addr, out_valid);
                end
                stall_n++;
            end else begin
                out_ready = 1'b1;
            end
            tick();
            n++;
        end
        out_ready = 1'b1;
        checks++;
        if (stall_n != 3) begin
            errors++;
            $display("FAIL stall_count: got %0d stall cycles, required 3", stall_n);
        end
        checks++;
        if (got_q.size() != 130) begin
            errors++;
            $display("FAIL bp_len: got %0d bytes, required 130", got_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (get_byte(i) !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_byte[%0d]: got %h, required %h", i, get_byte(i), exp_q[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int n;
        load_pattern();
        build_expected();
        clear_capture();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 400) begin
            start = (got_q.size() == 40);
            tick();
            n++;
        end
        start = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL busy_done_count: got %0d done pulses, required 1", done_cnt);
        end
        checks++;
        if (got_q.size() != 130 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_len: got %0d bytes busy=%b, required 130 bytes busy=0", got_q.size(), busy);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (get_byte(i) !== exp_q[i]) begin
                errors++;
                $display("FAIL busy_byte[%0d]: got %h, required %h", i, get_byte(i), exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_dump();
        int n;
        bit to;
        load_pattern();
        build_expected();
        clear_capture();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (got_q.size() < 30 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (rd_addr !== 5'd7 || out_valid !== 1'b1 || out_data !== exp_q[30]) begin
            errors++;
            $display("FAIL mid_pre_reset: rd_addr=%0d valid=%b data=%h, required 7 1 %h",
                     rd_addr, out_valid, out_data, exp_q[30]);
        end
        rst = 1'b1;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || rd_addr !== 5'd0 ||
            out_data !== 8'h00 || fsm_state !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset_vals: busy=%b valid=%b done=%b rd_addr=%0d data=%h state=%0d, required all 0",
                     busy, out_valid, done, rd_addr, out_data, fsm_state);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 15; k++) tick();
        checks++;
        if (got_q.size() != 30 || done_cnt != 0) begin
            errors++;
            $display("FAIL mid_no_csum: got %0d bytes %0d done, required 30 bytes 0 done", got_q.size(), done_cnt);
        end
        clear_capture();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(400, to);
        checks++;
        if (to || got_q.size() != 130) begin
            errors++;
            $display("FAIL mid_restart_len: got %0d bytes timeout=%0d, required 130 bytes", got_q.size(), to);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (get_byte(i) !== exp_q[i]) begin
                errors++;
                $display("FAIL mid_byte[%0d]: got %h, required %h", i, get_byte(i), exp_q[i]);
            end
        end
    endtask

    task automatic test_snapshot();
        int n;
        bit written;
        load_pattern();
        regs[5] = 32'h0;
        build_expected();
        clear_capture();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        written = 1'b0;
        while (done_cnt == 0 && n < 400) begin
            if (!written && got_q.size() == 21 && out_valid === 1'b1) begin
                checks++;
                if (rd_addr !== 5'd5) begin
                    errors++;
                    $display("FAIL snap_addr: got %0d, required 5", rd_addr);
                end
                regs[5] = 32'h12345678;
                written = 1'b1;
            end
            tick();
            n++;
        end
        checks++;
        if (!written || got_q.size() != 130) begin
            errors++;
            $display("FAIL snap_len: written=%0d got %0d bytes, required 1 and 130", written, got_q.size());
        end
        checks++;
        if (get_byte(21) !== 8'h00 || get_byte(22) !== 8'h00 ||
            get_byte(23) !== 8'h00 || get_byte(24) !== 8'h00) begin
            errors++;
            $display("FAIL snap_reg5: got %h %h %h %h, required 00 00 00 00",
                     get_byte(21), get_byte(22), get_byte(23), get_byte(24));
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (get_byte(i) !== exp_q[i]) begin
                errors++;
                $display("FAIL snap_byte[%0d]: got %h, required %h", i, get_byte(i), exp_q[i]);
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        clear_capture();

        test_reset();
        test_full_dump();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_dump();
        test_snapshot();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_dump_ctrl.md
Name: reg_dump_ctrl

Overview:
- Read-side companion to the 32x32 central register file.
- On a start pulse, walks register addresses 0..NUM_REGS-1 through a register-file read port and captures each 32-bit value.
- Serialises the captured values into a byte stream with a header and an XOR checksum, over a valid/ready handshake.
- Feeds the debug/host link (UART TX or display shim) and is used for post-run register inspection.

Parameters:
- NUM_REGS, 32, number of registers dumped, starting at address 0 (range 1..32).
- ADDR_W, 5, register address width.
- HDR_BYTE, 8'hA5, frame header byte.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  dump request; sampled only in IDLE.
- rd_addr  out  ADDR_W  address to the register file read port.
- rd_data  in  32  register file read data; combinational, valid in the same cycle as rd_addr.
- out_data  out  8  stream byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the byte.
- busy  out  1  high from the cycle after start is accepted until DONE is exited.
- done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (rst high at posedge): state=IDLE, rd_addr=0, out_data=0, out_valid=0, busy=0, done=0, checksum=0, index=0, byte count=0.
  - Reset takes priority over everything, including in the middle of a dump.
  - A partially sent frame is abandoned; no checksum is emitted.
- Frame format: HDR_BYTE, then for each register i=0..NUM_REGS-1 four bytes, most significant first, then a CSUM byte.
  - CSUM = XOR of all 4*NUM_REGS data bytes; the header is excluded.
  - Total frame length 4*NUM_REGS+2 bytes (130 at default).
- Transfer rule: a byte moves on a posedge where out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data and rd_addr hold stable.
  - out_valid never drops without a transfer.
- States:
  - IDLE: busy=0, out_valid=0. On start=1, go to HDR, clear checksum, index=0.
  - HDR: out_valid=1, out_data=HDR_BYTE. On transfer, go to LOAD.
  - LOAD (1 cycle, out_valid=0): rd_addr=index; capture rd_data into a 32-bit shift register; byte count=0. Go to SEND.
  - SEND: out_valid=1, out_data=shift[31:24].
    - On each transfer, XOR the byte into checksum, shift left by 8, byte count+1.
    - After the 4th transfer: if index==NUM_REGS-1, go to CSUM; otherwise index+1 and go to LOAD.
  - CSUM: out_valid=1, out_data=checksum. On transfer, go to DONE.
  - DONE (1 cycle): done=1, busy=1, out_valid=0. Go to IDLE.
- Timing and rd_addr:
  - busy=1 in every state other than IDLE.
  - Latency from the start-accept edge to first out_valid is 1 cycle.
  - rd_addr equals index in LOAD and SEND, holds its last value in CSUM/DONE, and returns to 0 in IDLE.
- Boundary conditions:
  - start while busy: ignored, with no restart or queueing.
  - start held high through DONE: a new frame starts from the IDLE cycle following DONE.
  - Snapshot consistency: each register is sampled exactly once, in its LOAD cycle. Register-file writes after that cycle do not alter bytes already captured; the CPU is expected to be halted during a dump.
  - Index arithmetic is ADDR_W+1 bits wide so the NUM_REGS=32 comparison does not wrap.
- Throughput: with out_ready=1 throughout, one frame takes 1+5*NUM_REGS+1+1 cycles from HDR entry to DONE (163 at default).

Test Plan:
1. Reset state: rst=1 for 2 cycles with start=1 -> busy=0, out_valid=0, done=0, rd_addr=0 throughout, and nothing starts while rst is high.
2. Full dump: all registers 0 except reg12=32'hDEADBEEF, out_ready=1 -> 130 bytes.
   - Byte 0 = 8'hA5; bytes 49..52 = DE AD BE EF; last byte = 8'h22.
   - done pulses exactly 162 cycles after out_valid first rises.
3. Backpressure: out_ready=0 for 3 cycles while AD of reg12 is presented -> out_data stays 8'hAD, rd_addr stays 12 and out_valid stays 1. Resulting stream is identical to test 2.
4. Start while busy: pulse start at byte 40 -> a single frame of 130 bytes and a single done pulse.
5. Reset mid-dump: assert rst while reg7 is being sent -> outputs return to reset values next cycle and no CSUM byte appears. A new start then yields a full, correct 130-byte frame.
6. Snapshot: write reg5=32'h12345678 to the register file during reg5's SEND state after its LOAD captured 0 -> frame carries 00 00 00 00 for reg5.
